// File: rtl/data_memory_lsu.sv
// Single-port word memory behind a load/store unit with a fixed response latency.
// Handles byte/half/word accesses with lane masking, alignment/range errors and load extension.
module data_memory_lsu #(
   parameter int DEPTH    = 1024,
   parameter int READ_LAT = 1
) (
   input  logic        clk_i,
   input  logic        reset_ni,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [1:0]  req_size_i,
   input  logic        req_unsigned_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        rsp_valid_o,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_err_o
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t        state, state_nxt;
   logic [1:0]    cnt, cnt_nxt;
   logic [31:0]   mem [DEPTH];

   logic          accept;
   logic          range_err;
   logic          req_err;
   logic [AW-1:0] idx;
   logic [31:0]   rd_word;
   logic [31:0]   load_ext;
   logic [31:0]   wdata_al;
   logic [3:0]    be;

   logic [31:0]   rdata_p1;
   logic          err_p1;

   function automatic logic [31:0] extend(input logic [31:0] word, input logic [1:0] ofs,
                                          input logic [1:0] size, input logic uns);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{ofs, 3'b000} +: 8];
      h = ofs[1] ? word[31:16] : word[15:0];
      case (size)
         2'd0:    extend = uns ? {24'd0, b} : {{24{b[7]}}, b};
         2'd1:    extend = uns ? {16'd0, h} : {{16{h[15]}}, h};
         default: extend = word;
      endcase
   endfunction

   assign req_ready_o = reset_ni && (state != WAIT);
   assign accept      = req_valid_i && req_ready_o;
   assign idx         = req_addr_i[AW+1:2];
   assign range_err   = (req_addr_i >> (AW + 2)) != 32'd0;
   assign rd_word     = mem[idx];
   assign load_ext    = extend(rd_word, req_addr_i[1:0], req_size_i, req_unsigned_i);

   always_comb begin
      req_err  = range_err;
      wdata_al = req_wdata_i;
      be       = 4'b0000;
      case (req_size_i)
         2'd0: begin
            wdata_al = {4{req_wdata_i[7:0]}};
            be       = 4'b0001 << req_addr_i[1:0];
         end
         2'd1: begin
            req_err  = range_err || req_addr_i[0];
            wdata_al = {2{req_wdata_i[15:0]}};
            be       = req_addr_i[1] ? 4'b1100 : 4'b0011;
         end
         2'd2: begin
            req_err  = range_err || (req_addr_i[1:0] != 2'b00);
            be       = 4'b1111;
         end
         default: req_err = 1'b1;
      endcase
   end

   // Next-state: a response cycle can accept the following request back-to-back
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE, RESP: begin
            state_nxt = IDLE;
            if (accept) begin
               if (READ_LAT == 1) begin
                  state_nxt = RESP;
               end else begin
                  state_nxt = WAIT;
                  cnt_nxt   = 2'(READ_LAT - 1);
               end
            end
         end
         WAIT: begin
            cnt_nxt = cnt - 2'd1;
            if (cnt == 2'd1) state_nxt = RESP;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state <= IDLE;
         cnt   <= 2'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Stage p1: stores commit and load data is captured on the accept edge
   always_ff @(posedge clk_i) begin
      if (accept) begin
         rdata_p1 <= (req_we_i || req_err) ? 32'd0 : load_ext;
         err_p1   <= req_err;
         for (int i = 0; i < 4; i++) begin
            if (req_we_i && !req_err && be[i]) mem[idx][8*i +: 8] <= wdata_al[8*i +: 8];
         end
      end
   end

   assign rsp_valid_o = (state == RESP);
   assign rsp_rdata_o = (state == RESP) ? rdata_p1 : 32'd0;
   assign rsp_err_o   = (state == RESP) ? err_p1 : 1'b0;

endmodule
